// File: rtl/timer_counter.sv
// Programmable down-counter timer with CTRL/PRESET/COUNT word registers.
// Raises a level irq on terminal count (one-shot) or a one-cycle pulse (auto-reload).
module timer_counter #(
  parameter logic [31:0] PRESET_RST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:2]  addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  localparam int          DATA_W    = 32;
  localparam logic [31:0] CTRL_MASK = 32'h0000_000F;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CNT,
    S_INT
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [DATA_W-1:0]   ctrl;
  logic [DATA_W-1:0]   preset;
  logic [DATA_W-1:0]   count;
  logic [DATA_W-1:0]   count_nxt;
  logic                pending;
  logic                pend_set;
  logic                pend_clr_fsm;
  logic                en_clr;
  logic                en;
  logic                im;
  logic                mode_auto;
  logic                wr_ctrl;
  logic                wr_preset;

  assign en        = ctrl[0];
  assign im        = ctrl[3];
  assign mode_auto = (ctrl[2:1] == 2'b01);
  assign wr_ctrl   = we && (addr == 2'd0);
  assign wr_preset = we && (addr == 2'd1);

  always_comb begin
    state_nxt    = state;
    count_nxt    = count;
    pend_set     = 1'b0;
    pend_clr_fsm = 1'b0;
    en_clr       = 1'b0;
    case (state)
      S_IDLE: begin
        if (en) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        count_nxt = preset;
        state_nxt = S_CNT;
      end
      S_CNT: begin
        if (!en) begin
          state_nxt = S_IDLE;
        end else if (count > 32'd1) begin
          count_nxt = count - 32'd1;
        end else begin
          // A preset of 0 expires just like a preset of 1
          count_nxt = '0;
          pend_set  = 1'b1;
          state_nxt = S_INT;
        end
      end
      S_INT: begin
        if (mode_auto) begin
          pend_clr_fsm = 1'b1;
          state_nxt    = S_LOAD;
        end else begin
          en_clr    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      ctrl    <= '0;
      preset  <= PRESET_RST;
      count   <= '0;
      pending <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      // A bus write to CTRL overrides the FSM's EN clear in the same cycle
      if (wr_ctrl)
        ctrl <= din & CTRL_MASK;
      else if (en_clr)
        ctrl[0] <= 1'b0;
      if (wr_preset)
        preset <= din;
      // Terminal count beats a simultaneous software acknowledge
      if (pend_set)
        pending <= 1'b1;
      else if (wr_ctrl || wr_preset || pend_clr_fsm)
        pending <= 1'b0;
    end
  end

  always_comb begin
    dout = '0;
    case (addr)
      2'd0:    dout = ctrl;
      2'd1:    dout = preset;
      2'd2:    dout = count;
      default: dout = '0;
    endcase
  end

  assign irq = pending & im;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: one-shot, auto-reload, pause/reload,
// masking/acknowledge ordering, mid-count PRESET writes and reset.
module tb_timer_counter;

  localparam logic [31:0] PRST = 32'h0000_0007;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:2]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  timer_counter #(.PRESET_RST(PRST)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .din   (din),
    .dout  (dout),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr = a;
    din  = d;
    we   = 1'b1;
    step(1);
    we   = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, dout, exp);
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    chk(tag, {31'b0, irq}, {31'b0, exp});
  endtask

  initial begin
    int pulses;
    int ct[5];
    logic exp_irq;
    ct = '{0, 0, 3, 2, 1};
    reset = 1'b1;
    we    = 1'b0;
    addr  = 2'd0;
    din   = '0;
    step(2);
    reset = 1'b0;

    // Reset state and reserved address
    chk_irq("rst_irq", 1'b0);
    chk_rd("rst_ctrl", 2'd0, 32'h0);
    chk_rd("rst_preset", 2'd1, PRST);
    chk_rd("rst_count", 2'd2, 32'h0);
    wr(2'd3, 32'hFFFF_FFFF);
    chk_rd("addr3_read", 2'd3, 32'h0);
    chk_rd("addr3_wr_preset", 2'd1, PRST);
    chk_rd("addr3_wr_ctrl", 2'd0, 32'h0);

    // 1: one-shot, PRESET=5, EN+IM
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    step(1);
    chk_rd("t1_load_count", 2'd2, 32'd0);
    for (int i = 5; i >= 1; i--) begin
      step(1);
      chk_rd($sformatf("t1_count%0d", i), 2'd2, i);
      chk_irq($sformatf("t1_irq_low%0d", i), 1'b0);
    end
    step(1);
    chk_rd("t1_count0", 2'd2, 32'd0);
    chk_irq("t1_irq_set", 1'b1);
    step(1);
    chk_rd("t1_ctrl_en_clr", 2'd0, 32'h8);
    chk_irq("t1_irq_hold1", 1'b1);
    step(20);
    chk_irq("t1_irq_hold20", 1'b1);
    wr(2'd0, 32'h8);
    chk_irq("t1_irq_ack", 1'b0);

    // 2: auto-reload, PRESET=3 -> pulse every 5 cycles
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    pulses = 0;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      exp_irq = ((k % 5) == 0);
      chk_irq($sformatf("t2_irq_k%0d", k), exp_irq);
      chk_rd($sformatf("t2_count_k%0d", k), 2'd2, ct[k % 5]);
      if (irq) pulses++;
    end
    chk("t2_pulses", pulses, 32'd4);
    wr(2'd0, 32'h0);
    step(3);
    chk_irq("t2_stopped_irq", 1'b0);
    chk_rd("t2_stopped_ctrl", 2'd0, 32'h0);

    // 3: pause at COUNT=6, then re-enable reloads full period
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h9);
    step(5);
    wr(2'd0, 32'h8);
    chk_rd("t3_count6", 2'd2, 32'd6);
    step(3);
    chk_rd("t3_frozen", 2'd2, 32'd6);
    chk_irq("t3_frozen_irq", 1'b0);
    wr(2'd0, 32'h9);
    step(2);
    chk_rd("t3_reload", 2'd2, 32'd10);
    step(9);
    chk_rd("t3_count1", 2'd2, 32'd1);
    chk_irq("t3_irq_pre", 1'b0);
    step(1);
    chk_irq("t3_irq", 1'b1);
    step(1);
    wr(2'd0, 32'h8);
    chk_irq("t3_ack", 1'b0);

    // 4: masked terminal count, acknowledge ordering, set-beats-ack
    wr(2'd1, 32'd4);
    wr(2'd0, 32'h1);
    step(6);
    chk_rd("t4_count0", 2'd2, 32'd0);
    chk_irq("t4_masked", 1'b0);
    step(1);
    chk_rd("t4_ctrl", 2'd0, 32'h0);
    wr(2'd0, 32'h8);
    chk_irq("t4_ack_im", 1'b0);
    wr(2'd0, 32'h1);
    step(7);
    wr(2'd0, 32'h0);
    wr(2'd0, 32'h8);
    chk_irq("t4_ack_order", 1'b0);
    wr(2'd0, 32'h1);
    step(5);
    wr(2'd0, 32'h8);
    chk_irq("t4_set_wins", 1'b1);
    step(3);
    chk_irq("t4_set_hold", 1'b1);
    chk_rd("t4_set_ctrl", 2'd0, 32'h8);
    wr(2'd0, 32'h8);
    chk_irq("t4_set_ack", 1'b0);

    // 5: auto-reload PRESET=8, PRESET=2 written mid-count, COUNT write ignored
    wr(2'd1, 32'd8);
    wr(2'd0, 32'hB);
    step(2);
    chk_rd("t5_count8", 2'd2, 32'd8);
    wr(2'd1, 32'd2);
    chk_rd("t5_count7", 2'd2, 32'd7);
    wr(2'd2, 32'h0000_FFFF);
    chk_rd("t5_count_wr_ign", 2'd2, 32'd6);
    step(6);
    chk_irq("t5_irq1", 1'b1);
    chk_rd("t5_term", 2'd2, 32'd0);
    step(1);
    chk_irq("t5_load_irq", 1'b0);
    step(1);
    chk_rd("t5_newp", 2'd2, 32'd2);
    step(1);
    chk_rd("t5_newp1", 2'd2, 32'd1);
    step(1);
    chk_irq("t5_irq2", 1'b1);

    // 6: reset while irq high, then PRESET=0 one-shot, write during INT
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk_irq("t6_rst_irq", 1'b0);
    chk_rd("t6_rst_ctrl", 2'd0, 32'h0);
    chk_rd("t6_rst_count", 2'd2, 32'h0);
    chk_rd("t6_rst_preset", 2'd1, PRST);
    step(2);
    chk_rd("t6_idle_count", 2'd2, 32'h0);
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    step(2);
    chk_irq("t6_p0_pre", 1'b0);
    step(1);
    chk_irq("t6_p0_irq", 1'b1);
    wr(2'd0, 32'h9);
    chk_irq("t6_int_wr_ack", 1'b0);
    chk_rd("t6_int_wr_ctrl", 2'd0, 32'h9);
    step(3);
    chk_irq("t6_restart_irq", 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
